// File: rtl/mesm6_mem_arbiter.sv
// Merges the mesm6_core instruction and data buses onto one single-ported
// 32K x 48-bit memory, with registered read data, done pulses and a watchdog.
module mesm6_mem_arbiter #(
  parameter int ROUND_ROBIN = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ibus_fetch,
  input  logic [14:0] ibus_addr,
  output logic [47:0] ibus_input,
  output logic        ibus_done,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [14:0] dbus_addr,
  input  logic [47:0] dbus_output,
  output logic [47:0] dbus_input,
  output logic        dbus_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [47:0] mem_wdata,
  input  logic [47:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IACC = 2'd1,
    ST_DACC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Watchdog value at which the access is given up (counter starts at zero).
  localparam logic [7:0]  WD_LIMIT = 8'(TIMEOUT - 1);
  localparam logic [47:0] ERR_DATA = 48'hFFFF_FFFF_FFFF;

  state_t      state_r;
  state_t      state_next_s;
  logic [7:0]  watchdog_r;
  logic        last_grant_d_r;
  logic        i_pend_s;
  logic        d_pend_s;
  logic        in_acc_s;
  logic        grant_i_s;
  logic        grant_d_s;
  logic        ack_s;
  logic        expire_s;
  logic        finish_s;

  logic        mem_req_r;
  logic        mem_we_r;
  logic [14:0] mem_addr_r;
  logic [47:0] mem_wdata_r;
  logic [47:0] ibus_input_r;
  logic [47:0] dbus_input_r;
  logic        ibus_done_r;
  logic        dbus_done_r;
  logic        bus_error_r;

  assign i_pend_s = ibus_fetch;
  assign d_pend_s = dbus_read | dbus_write;
  assign in_acc_s = (state_r == ST_IACC) || (state_r == ST_DACC);
  assign finish_s = ack_s | expire_s;

  // Next-state, grant and access-termination decode
  always_comb begin
    state_next_s = state_r;
    grant_i_s    = 1'b0;
    grant_d_s    = 1'b0;
    ack_s        = 1'b0;
    expire_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_pend_s && d_pend_s) begin
          if ((ROUND_ROBIN == 0) || !last_grant_d_r) begin
            grant_d_s = 1'b1;
          end else begin
            grant_i_s = 1'b1;
          end
        end else if (i_pend_s) begin
          grant_i_s = 1'b1;
        end else if (d_pend_s) begin
          grant_d_s = 1'b1;
        end else begin
          grant_i_s = 1'b0;
        end
        if (grant_i_s) begin
          state_next_s = ST_IACC;
        end else if (grant_d_s) begin
          state_next_s = ST_DACC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_IACC, ST_DACC: begin
        // An acknowledge in the same cycle as expiry still completes normally.
        if (mem_ack) begin
          ack_s        = 1'b1;
          state_next_s = ST_DONE;
        end else if (watchdog_r == WD_LIMIT) begin
          expire_s     = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Memory-side strobe, address, write data and last-grant tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_r      <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= 15'd0;
      mem_wdata_r    <= 48'd0;
      last_grant_d_r <= 1'b0;
    end else if (grant_i_s) begin
      mem_req_r      <= 1'b1;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= ibus_addr;
      mem_wdata_r    <= 48'd0;
      last_grant_d_r <= 1'b0;
    end else if (grant_d_s) begin
      mem_req_r      <= 1'b1;
      mem_we_r       <= dbus_write;
      mem_addr_r     <= dbus_addr;
      mem_wdata_r    <= dbus_output;
      last_grant_d_r <= 1'b1;
    end else if (finish_s) begin
      mem_req_r      <= 1'b0;
      mem_we_r       <= 1'b0;
    end
  end

  // Watchdog: counts unacknowledged access cycles, clears outside an access
  always_ff @(posedge clk) begin
    if (reset) begin
      watchdog_r <= 8'd0;
    end else if (in_acc_s && !finish_s) begin
      watchdog_r <= watchdog_r + 8'd1;
    end else begin
      watchdog_r <= 8'd0;
    end
  end

  // Completion pulses and per-port read data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      ibus_done_r  <= 1'b0;
      dbus_done_r  <= 1'b0;
      bus_error_r  <= 1'b0;
      ibus_input_r <= 48'd0;
      dbus_input_r <= 48'd0;
    end else begin
      ibus_done_r <= (state_r == ST_IACC) && finish_s;
      dbus_done_r <= (state_r == ST_DACC) && finish_s;
      bus_error_r <= expire_s;
      if ((state_r == ST_IACC) && ack_s) begin
        ibus_input_r <= mem_rdata;
      end else if ((state_r == ST_IACC) && expire_s) begin
        ibus_input_r <= ERR_DATA;
      end
      // Writes leave the data-side read register untouched.
      if ((state_r == ST_DACC) && !mem_we_r && ack_s) begin
        dbus_input_r <= mem_rdata;
      end else if ((state_r == ST_DACC) && !mem_we_r && expire_s) begin
        dbus_input_r <= ERR_DATA;
      end
    end
  end

  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign ibus_input = ibus_input_r;
  assign dbus_input = dbus_input_r;
  assign ibus_done  = ibus_done_r;
  assign dbus_done  = dbus_done_r;
  assign bus_error  = bus_error_r;

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// Randomised self-checking bench for mesm6_mem_arbiter: a fixed-priority
// instance carries most scenarios, a round-robin instance covers tie-breaking.
module tb_mesm6_mem_arbiter;

  localparam int          TO   = 4;
  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        ibus_fetch, dbus_read, dbus_write, mem_ack;
  logic [14:0] ibus_addr, dbus_addr;
  logic [47:0] dbus_output, mem_rdata;
  logic [47:0] ibus_input, dbus_input, mem_wdata;
  logic        ibus_done, dbus_done, mem_req, mem_we, bus_error;
  logic [14:0] mem_addr;

  logic        r_ibus_fetch, r_dbus_read, r_dbus_write, r_mem_ack;
  logic [14:0] r_ibus_addr, r_dbus_addr;
  logic [47:0] r_dbus_output, r_mem_rdata;
  logic [47:0] r_ibus_input, r_dbus_input, r_mem_wdata;
  logic        r_ibus_done, r_dbus_done, r_mem_req, r_mem_we, r_bus_error;
  logic [14:0] r_mem_addr;

  mesm6_mem_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(TO)) dut0 (
    .clk(clk), .reset(reset),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr), .ibus_input(ibus_input), .ibus_done(ibus_done),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
    .dbus_output(dbus_output), .dbus_input(dbus_input), .dbus_done(dbus_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_error(bus_error)
  );

  mesm6_mem_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(TO)) dut1 (
    .clk(clk), .reset(reset),
    .ibus_fetch(r_ibus_fetch), .ibus_addr(r_ibus_addr), .ibus_input(r_ibus_input), .ibus_done(r_ibus_done),
    .dbus_read(r_dbus_read), .dbus_write(r_dbus_write), .dbus_addr(r_dbus_addr),
    .dbus_output(r_dbus_output), .dbus_input(r_dbus_input), .dbus_done(r_dbus_done),
    .mem_req(r_mem_req), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_rdata(r_mem_rdata), .mem_ack(r_mem_ack), .bus_error(r_bus_error)
  );

  int tests = 0;
  int fails = 0;

  // Environment / monitor state for dut0
  int          idone_cnt = 0, ddone_cnt = 0, err_cnt = 0, strobe_cnt = 0;
  int          unstable_cnt = 0, req_len = 0, wait_cfg = 0;
  bit          prev_req = 1'b0, env_en = 1'b1, last_ack_we = 1'b0;
  logic [14:0] last_ack_addr, req_addr_h;
  logic [47:0] req_wdata_h;
  logic        req_we_h;
  logic [14:0] grant_q[$];
  logic [47:0] env_mem[logic [14:0]];
  // Reference model: core-visible memory contents and expected read registers
  logic [47:0] ref_mem[logic [14:0]];
  logic [47:0] exp_iin, exp_din;
  // dut1 monitor
  bit          r_prev = 1'b0;
  logic [14:0] r_grant_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit expired");
  end

  function automatic logic [47:0] init_val(input logic [14:0] a);
    return {a, ~a, a ^ 15'h2A5A, 3'b101};
  endfunction

  function automatic logic [47:0] ref_read(input logic [14:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [47:0] rand48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[47:0];
  endfunction

  // One clock: observe outputs after the edge, then drive the memory responses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ibus_done === 1'b1) idone_cnt++;
    if (dbus_done === 1'b1) ddone_cnt++;
    if (bus_error === 1'b1) err_cnt++;
    if (mem_req === 1'b1) begin
      if (!prev_req) begin
        strobe_cnt++;
        grant_q.push_back(mem_addr);
        req_addr_h  = mem_addr;
        req_wdata_h = mem_wdata;
        req_we_h    = mem_we;
        req_len     = 0;
      end
      req_len++;
      if (mem_addr !== req_addr_h || mem_wdata !== req_wdata_h || mem_we !== req_we_h) unstable_cnt++;
    end
    prev_req = (mem_req === 1'b1);
    if (env_en) begin
      mem_ack   = 1'b0;
      mem_rdata = rand48();
      if (mem_req === 1'b1 && wait_cfg >= 0 && req_len == wait_cfg + 1) begin
        mem_ack = 1'b1;
        if (mem_we) env_mem[mem_addr] = mem_wdata;
        mem_rdata     = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_val(mem_addr);
        last_ack_addr = mem_addr;
        last_ack_we   = mem_we;
      end
    end
    if (r_mem_req === 1'b1 && !r_prev) r_grant_q.push_back(r_mem_addr);
    r_prev      = (r_mem_req === 1'b1);
    r_mem_ack   = (r_mem_req === 1'b1) && (r_mem_ack !== 1'b1);
    r_mem_rdata = init_val(r_mem_addr);
  endtask

  // One complete core access on dut0, checked against the reference model.
  task automatic do_access(input bit is_d, input bit wr, input logic [14:0] addr,
                           input logic [47:0] wd, input int waits, input string tag);
    int lat, s0, e0, exp_lat, exp_len;
    bit seen, tmo;
    logic [47:0] rd;
    s0 = strobe_cnt; e0 = err_cnt; tmo = (waits < 0);
    rd = tmo ? ONES : ref_read(addr);
    exp_lat = tmo ? TO + 1 : waits + 2;
    exp_len = tmo ? TO : waits + 1;
    wait_cfg = waits;
    if (is_d) begin
      dbus_addr = addr; dbus_output = wd; dbus_read = !wr; dbus_write = wr;
    end else begin
      ibus_addr = addr; ibus_fetch = 1'b1;
    end
    seen = 1'b0; lat = 0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      seen = is_d ? (dbus_done === 1'b1) : (ibus_done === 1'b1);
    end
    if (!is_d) exp_iin = rd;
    else if (!wr) exp_din = rd;
    else if (!tmo) ref_mem[addr] = wd;
    tests++;
    if (!seen) begin fails++; $display("FAIL %s done: no done pulse within %0d cycles", tag, lat); end
    tests++;
    if (lat != exp_lat) begin fails++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat); end
    tests++;
    if (ibus_input !== exp_iin || dbus_input !== exp_din) begin
      fails++;
      $display("FAIL %s data: ibus_input=%h dbus_input=%h want %h %h", tag, ibus_input, dbus_input, exp_iin, exp_din);
    end
    tests++;
    if (bus_error !== tmo || (err_cnt - e0) != (tmo ? 1 : 0)) begin
      fails++;
      $display("FAIL %s bus_error: got %b (pulses %0d) want %b", tag, bus_error, err_cnt - e0, tmo);
    end
    tests++;
    if ((is_d ? ibus_done : dbus_done) !== 1'b0) begin
      fails++; $display("FAIL %s other_done: other port done asserted, want 0", tag);
    end
    tests++;
    if ((strobe_cnt - s0) != 1 || req_len != exp_len) begin
      fails++;
      $display("FAIL %s strobe: strobes %0d len %0d want 1 len %0d", tag, strobe_cnt - s0, req_len, exp_len);
    end
    if (!tmo) begin
      tests++;
      if (last_ack_addr !== addr || last_ack_we !== (is_d & wr)) begin
        fails++;
        $display("FAIL %s mem_bus: addr %h we %b want %h %b", tag, last_ack_addr, last_ack_we, addr, is_d & wr);
      end
    end
    tick();  // core still holds the request during the done cycle
    tests++;
    if (ibus_done !== 1'b0 || dbus_done !== 1'b0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL %s after_done: idone %b ddone %b mem_req %b want 0 0 0", tag, ibus_done, dbus_done, mem_req);
    end
    ibus_fetch = 1'b0; dbus_read = 1'b0; dbus_write = 1'b0;
  endtask

  task automatic test_reset();
    ibus_fetch = 1'b0; dbus_read = 1'b0; dbus_write = 1'b0; mem_ack = 1'b0;
    ibus_addr = 15'd0; dbus_addr = 15'd0; dbus_output = 48'd0; mem_rdata = 48'd0;
    r_ibus_fetch = 1'b0; r_dbus_read = 1'b0; r_dbus_write = 1'b0; r_mem_ack = 1'b0;
    r_ibus_addr = 15'd0; r_dbus_addr = 15'd0; r_dbus_output = 48'd0; r_mem_rdata = 48'd0;
    reset = 1'b1;
    repeat (3) tick();
    tests++;
    if ({mem_req, mem_we, ibus_done, dbus_done, bus_error} !== 5'b0 || mem_addr !== 15'd0 ||
        mem_wdata !== 48'd0 || ibus_input !== 48'd0 || dbus_input !== 48'd0) begin
      fails++;
      $display("FAIL reset_dut0: req %b we %b addr %h in %h/%h want all zero", mem_req, mem_we, mem_addr, ibus_input, dbus_input);
    end
    tests++;
    if ({r_mem_req, r_ibus_done, r_dbus_done, r_bus_error} !== 4'b0 || r_ibus_input !== 48'd0 || r_dbus_input !== 48'd0) begin
      fails++;
      $display("FAIL reset_dut1: req %b in %h/%h want all zero", r_mem_req, r_ibus_input, r_dbus_input);
    end
    reset = 1'b0;
    repeat (2) tick();
    tests++;
    if (mem_req !== 1'b0 || strobe_cnt != 0) begin
      fails++; $display("FAIL idle_after_reset: mem_req %b strobes %0d want 0 0", mem_req, strobe_cnt);
    end
    exp_iin = 48'd0; exp_din = 48'd0;
  endtask

  task automatic test_fetch_basic();
    env_mem[15'o00100] = 48'h1234_5678_9ABC;
    ref_mem[15'o00100] = 48'h1234_5678_9ABC;
    do_access(1'b0, 1'b0, 15'o00100, 48'd0, 0, "fetch_basic");
    repeat (3) tick();
    tests++;
    if (ibus_input !== 48'h1234_5678_9ABC) begin
      fails++; $display("FAIL fetch_hold: ibus_input %h want 123456789abc", ibus_input);
    end
    do_access(1'b1, 1'b0, 15'h0042, 48'd0, 2, "read_after_fetch");
  endtask

  task automatic test_write_waits();
    int u0;
    u0 = unstable_cnt;
    do_access(1'b1, 1'b1, 15'o77777, 48'hAAAA_5555_AAAA, 3, "write_waits");
    tests++;
    if (unstable_cnt != u0 || !env_mem.exists(15'o77777) || env_mem[15'o77777] !== 48'hAAAA_5555_AAAA) begin
      fails++; $display("FAIL write_mem: unstable %0d or memory word wrong, want aaaa5555aaaa stable", unstable_cnt - u0);
    end
    do_access(1'b1, 1'b0, 15'o77777, 48'd0, 1, "write_readback");
  endtask

  task automatic test_tie_fixed();
    int g0, cnt;
    g0 = grant_q.size();
    wait_cfg = 0;
    ibus_addr = 15'h0200; dbus_addr = 15'h0300; ibus_fetch = 1'b1; dbus_read = 1'b1;
    cnt = 0;
    while (dbus_done !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    tick();
    dbus_read = 1'b0;
    cnt = 0;
    while (ibus_done !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    tick();
    ibus_fetch = 1'b0;
    exp_iin = ref_read(15'h0200); exp_din = ref_read(15'h0300);
    tests++;
    if (grant_q.size() < g0 + 2) begin
      fails++; $display("FAIL tie_order: only %0d grants, want 2", grant_q.size() - g0);
    end else if (grant_q[g0] !== 15'h0300 || grant_q[g0+1] !== 15'h0200) begin
      fails++; $display("FAIL tie_order: grants %h,%h want 0300,0200", grant_q[g0], grant_q[g0+1]);
    end
    tests++;
    if (ibus_input !== exp_iin || dbus_input !== exp_din) begin
      fails++; $display("FAIL tie_data: %h/%h want %h/%h", ibus_input, dbus_input, exp_iin, exp_din);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] a;
    int s0, i0, g0, cnt;
    s0 = strobe_cnt; i0 = idone_cnt; g0 = grant_q.size();
    wait_cfg = 0;
    ibus_fetch = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 15'h0400 + 15'(k);
      ibus_addr = a;
      cnt = 0;
      while (ibus_done !== 1'b1 && cnt < 20) begin tick(); cnt++; end
      exp_iin = ref_read(a);
      tests++;
      if (ibus_input !== exp_iin) begin
        fails++; $display("FAIL b2b_data%0d: %h want %h", k, ibus_input, exp_iin);
      end
      tick();
    end
    ibus_fetch = 1'b0;
    repeat (6) tick();
    tests++;
    if ((strobe_cnt - s0) != 3 || (idone_cnt - i0) != 3) begin
      fails++; $display("FAIL b2b_count: strobes %0d dones %0d want 3 3", strobe_cnt - s0, idone_cnt - i0);
    end
    tests++;
    if (grant_q.size() < g0 + 3) begin
      fails++; $display("FAIL b2b_order: %0d grants want 3", grant_q.size() - g0);
    end else if (grant_q[g0] !== 15'h0400 || grant_q[g0+1] !== 15'h0401 || grant_q[g0+2] !== 15'h0402) begin
      fails++; $display("FAIL b2b_order: %h %h %h want 0400 0401 0402", grant_q[g0], grant_q[g0+1], grant_q[g0+2]);
    end
  endtask

  task automatic test_timeout();
    do_access(1'b0, 1'b0, 15'h0500, 48'd0, -1, "fetch_timeout");
    do_access(1'b1, 1'b0, 15'h0501, 48'd0, -1, "read_timeout");
    do_access(1'b0, 1'b0, 15'h0502, 48'd0, 0, "after_timeout");
  endtask

  task automatic test_random();
    logic [14:0] a;
    bit is_d, wr;
    for (int n = 0; n < 40; n++) begin
      is_d = ($urandom_range(0, 1) == 1);
      wr   = is_d && ($urandom_range(0, 1) == 1);
      a    = 15'h0100 + 15'($urandom_range(0, 7));
      do_access(is_d, wr, a, rand48(), int'($urandom_range(0, 3)), "random");
      repeat ($urandom_range(0, 2)) tick();
    end
    tests++;
    if (unstable_cnt != 0) begin
      fails++; $display("FAIL mem_stable: %0d unstable request cycles, want 0", unstable_cnt);
    end
  endtask

  task automatic test_round_robin();
    int g0, rg0;
    bit last_d, exp_d1;
    logic [14:0] want0, want1;
    g0 = grant_q.size(); rg0 = r_grant_q.size();
    wait_cfg = 0;
    ibus_addr = 15'h0600; dbus_addr = 15'h0700; ibus_fetch = 1'b1; dbus_read = 1'b1;
    r_ibus_addr = 15'h0600; r_dbus_addr = 15'h0700; r_ibus_fetch = 1'b1; r_dbus_read = 1'b1;
    repeat (20) tick();
    ibus_fetch = 1'b0; dbus_read = 1'b0; r_ibus_fetch = 1'b0; r_dbus_read = 1'b0;
    repeat (8) tick();
    last_d = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_d1 = !last_d;
      last_d = exp_d1;
      want0 = 15'h0700;
      want1 = exp_d1 ? 15'h0700 : 15'h0600;
      tests++;
      if (grant_q.size() <= g0 + k || grant_q[g0+k] !== want0) begin
        fails++; $display("FAIL fixed_prio_grant%0d: wrong or missing grant, want %h", k, want0);
      end
      tests++;
      if (r_grant_q.size() <= rg0 + k || r_grant_q[rg0+k] !== want1) begin
        fails++; $display("FAIL rr_grant%0d: wrong or missing grant, want %h", k, want1);
      end
    end
    tests++;
    if (r_ibus_input !== init_val(15'h0600) || r_dbus_input !== init_val(15'h0700)) begin
      fails++; $display("FAIL rr_data: %h/%h want %h/%h", r_ibus_input, r_dbus_input, init_val(15'h0600), init_val(15'h0700));
    end
  endtask

  task automatic test_reset_mid_access();
    int i0, d0, s0;
    wait_cfg = -1;
    dbus_addr = 15'h0123; dbus_read = 1'b1;
    tick();
    tick();
    tests++;
    if (mem_req !== 1'b1) begin fails++; $display("FAIL midreset_active: mem_req %b want 1", mem_req); end
    reset = 1'b1;
    tick();
    reset = 1'b0; dbus_read = 1'b0;
    tests++;
    if ({mem_req, mem_we, ibus_done, dbus_done, bus_error} !== 5'b0 || mem_addr !== 15'd0 ||
        mem_wdata !== 48'd0 || ibus_input !== 48'd0 || dbus_input !== 48'd0) begin
      fails++;
      $display("FAIL midreset_outputs: req %b addr %h in %h/%h want all zero", mem_req, mem_addr, ibus_input, dbus_input);
    end
    exp_iin = 48'd0; exp_din = 48'd0;
    i0 = idone_cnt; d0 = ddone_cnt; s0 = strobe_cnt;
    env_en = 1'b0;
    mem_ack = 1'b1; mem_rdata = 48'h0BAD_0BAD_0BAD;
    tick();
    mem_ack = 1'b0;
    repeat (5) tick();
    env_en = 1'b1;
    tests++;
    if (idone_cnt != i0 || ddone_cnt != d0 || strobe_cnt != s0 || dbus_input !== 48'd0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL late_ack: dones %0d/%0d strobes %0d dbus_input %h want none, 0", idone_cnt - i0, ddone_cnt - d0, strobe_cnt - s0, dbus_input);
    end
    do_access(1'b1, 1'b0, 15'h0124, 48'd0, -1, "post_reset_timeout");
    do_access(1'b0, 1'b0, 15'h0125, 48'd0, 0, "post_reset_fetch");
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_write_waits();
    test_tie_fixed();
    test_back_to_back();
    test_timeout();
    test_random();
    test_round_robin();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
